// File: rtl/xadc_sample_framer.sv
// xadc_sample_framer
//
// Pairs one XADC voltage sample with one current-monitor sample. Packs the two
// 12-bit results into a fixed-length byte frame:
//   SYNC, seq, V[11:4], {V[3:0], C[11:8]}, C[7:0] [, XOR of the five bytes]
// The frame goes out on an 8-bit AXI-Stream toward the FT232H sys_axis sink.
// One pair in every DECIMATE accepted pairs is framed. The other pairs are
// consumed and dropped.
//
// Optional build macro: XADC_SAMPLE_FRAMER_CHECKSUM_EN
//   When defined, the frame has a sixth byte: the XOR of bytes 0..4. That byte
//   carries tlast instead of byte 4.
//
// Ports
//   clk, rst_n                       block clock, asynchronous active-low reset
//   voltage_channel_*                AXIS sink, 12-bit sample in tdata[15:4]
//   current_monitor_channel_*        AXIS sink, 12-bit sample in tdata[15:4]
//   usb_axis_*                       AXIS source, framed byte stream
//   frame_count                      frames fully emitted, wraps at 16 bits
module xadc_sample_framer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned DECIMATE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [15:0] voltage_channel_tdata_i,
  input  logic        voltage_channel_tvalid_i,
  output logic        voltage_channel_tready_o,

  input  logic [15:0] current_monitor_channel_tdata_i,
  input  logic        current_monitor_channel_tvalid_i,
  output logic        current_monitor_channel_tready_o,

  output logic [7:0]  usb_axis_tdata_o,
  output logic        usb_axis_tvalid_o,
  input  logic        usb_axis_tready_i,
  output logic        usb_axis_tlast_o,
  output logic [0:0]  usb_axis_tkeep_o,
  output logic [0:0]  usb_axis_tid_o,
  output logic [0:0]  usb_axis_tdest_o,
  output logic [0:0]  usb_axis_tuser_o,

  output logic [15:0] frame_count
);

  localparam logic [7:0] DcntLast = 8'(DECIMATE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSeq,
    StD0,
    StD1,
    StD2
`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
    , StCsum
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] fc_q, fc_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [11:0] v_q, v_d;
  logic [11:0] c_q, c_d;

  logic        pair_avail;
  logic        frame_done;

  // The low nibbles of both channels hold no sample data.
  logic unused_low_bits;
  assign unused_low_bits = ^{voltage_channel_tdata_i[3:0],
                             current_monitor_channel_tdata_i[3:0]};

  // Both sides are taken in the same cycle, or neither is taken.
  assign pair_avail = (state_q == StIdle) && voltage_channel_tvalid_i &&
                      current_monitor_channel_tvalid_i;

  assign voltage_channel_tready_o         = pair_avail;
  assign current_monitor_channel_tready_o = pair_avail;

`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = SYNC_BYTE ^ seq_q ^ v_q[11:4] ^ {v_q[3:0], c_q[11:8]} ^ c_q[7:0];
`endif

  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    seq_d      = seq_q;
    fc_d       = fc_q;
    dcnt_d     = dcnt_q;
    v_d        = v_q;
    c_d        = c_q;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pair_avail) begin
          if (dcnt_q == DcntLast) begin
            dcnt_d   = '0;
            v_d      = voltage_channel_tdata_i[15:4];
            c_d      = current_monitor_channel_tdata_i[15:4];
            state_d  = StSync;
            tvalid_d = 1'b1;
            tdata_d  = SYNC_BYTE;
            tlast_d  = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
      end
      StSync: begin
        if (usb_axis_tready_i) begin
          state_d = StSeq;
          tdata_d = seq_q;
        end
      end
      StSeq: begin
        if (usb_axis_tready_i) begin
          state_d = StD0;
          tdata_d = v_q[11:4];
        end
      end
      StD0: begin
        if (usb_axis_tready_i) begin
          state_d = StD1;
          tdata_d = {v_q[3:0], c_q[11:8]};
        end
      end
      StD1: begin
        if (usb_axis_tready_i) begin
          state_d = StD2;
          tdata_d = c_q[7:0];
`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
          tlast_d = 1'b0;
`else
          tlast_d = 1'b1;
`endif
        end
      end
      StD2: begin
        if (usb_axis_tready_i) begin
`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
          state_d = StCsum;
          tdata_d = csum;
          tlast_d = 1'b1;
`else
          frame_done = 1'b1;
`endif
        end
      end
`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
      StCsum: begin
        if (usb_axis_tready_i) begin
          frame_done = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = StIdle;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

    if (frame_done) begin
      state_d  = StIdle;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tdata_d  = '0;
      seq_d    = seq_q + 8'd1;
      fc_d     = fc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      seq_q    <= '0;
      fc_q     <= '0;
      dcnt_q   <= '0;
      v_q      <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      seq_q    <= seq_d;
      fc_q     <= fc_d;
      dcnt_q   <= dcnt_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end

  assign usb_axis_tdata_o  = tdata_q;
  assign usb_axis_tvalid_o = tvalid_q;
  assign usb_axis_tlast_o  = tlast_q;
  assign usb_axis_tkeep_o  = '1;
  assign usb_axis_tid_o    = '0;
  assign usb_axis_tdest_o  = '0;
  assign usb_axis_tuser_o  = '0;
  assign frame_count       = fc_q;

endmodule

// File: tb/tb_xadc_sample_framer.sv
// Bench for xadc_sample_framer. Instance 0 uses DECIMATE=1. Instance 1 uses
// DECIMATE=4. Expected frame bytes are queued when a pair is handed to a DUT.
// A monitor pops and compares them on every output handshake.
module tb_xadc_sample_framer;

  localparam logic [7:0] Sync = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] v_tdata[2];
  logic [15:0] c_tdata[2];
  logic        v_tvalid[2];
  logic        c_tvalid[2];
  logic        v_tready[2];
  logic        c_tready[2];
  logic [7:0]  u_tdata[2];
  logic        u_tvalid[2];
  logic        u_tready[2];
  logic        u_tlast[2];
  logic [0:0]  u_tkeep[2];
  logic [0:0]  u_tid[2];
  logic [0:0]  u_tdest[2];
  logic [0:0]  u_tuser[2];
  logic [15:0] fc[2];

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mseq[2];
  int         checks = 0;
  int         passed = 0;

  xadc_sample_framer #(.SYNC_BYTE(Sync), .DECIMATE(1)) u_dut0 (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .voltage_channel_tdata_i          (v_tdata[0]),
    .voltage_channel_tvalid_i         (v_tvalid[0]),
    .voltage_channel_tready_o         (v_tready[0]),
    .current_monitor_channel_tdata_i  (c_tdata[0]),
    .current_monitor_channel_tvalid_i (c_tvalid[0]),
    .current_monitor_channel_tready_o (c_tready[0]),
    .usb_axis_tdata_o                 (u_tdata[0]),
    .usb_axis_tvalid_o                (u_tvalid[0]),
    .usb_axis_tready_i                (u_tready[0]),
    .usb_axis_tlast_o                 (u_tlast[0]),
    .usb_axis_tkeep_o                 (u_tkeep[0]),
    .usb_axis_tid_o                   (u_tid[0]),
    .usb_axis_tdest_o                 (u_tdest[0]),
    .usb_axis_tuser_o                 (u_tuser[0]),
    .frame_count                      (fc[0])
  );

  xadc_sample_framer #(.SYNC_BYTE(Sync), .DECIMATE(4)) u_dut1 (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .voltage_channel_tdata_i          (v_tdata[1]),
    .voltage_channel_tvalid_i         (v_tvalid[1]),
    .voltage_channel_tready_o         (v_tready[1]),
    .current_monitor_channel_tdata_i  (c_tdata[1]),
    .current_monitor_channel_tvalid_i (c_tvalid[1]),
    .current_monitor_channel_tready_o (c_tready[1]),
    .usb_axis_tdata_o                 (u_tdata[1]),
    .usb_axis_tvalid_o                (u_tvalid[1]),
    .usb_axis_tready_i                (u_tready[1]),
    .usb_axis_tlast_o                 (u_tlast[1]),
    .usb_axis_tkeep_o                 (u_tkeep[1]),
    .usb_axis_tid_o                   (u_tid[1]),
    .usb_axis_tdest_o                 (u_tdest[1]),
    .usb_axis_tuser_o                 (u_tuser[1]),
    .frame_count                      (fc[1])
  );

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_byte(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected bytes of one frame, built from the bench's own sequence model.
  task automatic push_frame(input int i, input logic [11:0] v, input logic [11:0] c);
    logic [7:0] b[5];
    b[0] = Sync;
    b[1] = mseq[i];
    b[2] = v[11:4];
    b[3] = {v[3:0], c[11:8]};
    b[4] = c[7:0];
    for (int k = 0; k < 4; k++) push_byte(i, {b[k], 1'b0});
`ifdef XADC_SAMPLE_FRAMER_CHECKSUM_EN
    push_byte(i, {b[4], 1'b0});
    push_byte(i, {b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4], 1'b1});
`else
    push_byte(i, {b[4], 1'b1});
`endif
    mseq[i] = mseq[i] + 8'd1;
  endtask

  // Output monitor: scoreboard pop on handshake, plus a hold check during stalls.
  logic       prev_stall[2];
  logic [7:0] prev_d[2];
  logic       prev_l[2];
  exp_t       mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (prev_stall[i]) begin
          checks++;
          if (u_tvalid[i] !== 1'b1 || u_tdata[i] !== prev_d[i] || u_tlast[i] !== prev_l[i])
            $display("FAIL stall_hold[%0d]: got valid=%b data=%h last=%b, expected 1 %h %b",
                     i, u_tvalid[i], u_tdata[i], u_tlast[i], prev_d[i], prev_l[i]);
          else passed++;
        end
        if (u_tvalid[i] === 1'b1 && u_tready[i] === 1'b1) begin
          checks++;
          if (qsize(i) == 0) begin
            $display("FAIL unexpected_byte[%0d]: got data=%h last=%b, expected none",
                     i, u_tdata[i], u_tlast[i]);
          end else begin
            mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (u_tdata[i] !== mon_e.d || u_tlast[i] !== mon_e.l)
              $display("FAIL frame_byte[%0d]: got data=%h last=%b, expected data=%h last=%b",
                       i, u_tdata[i], u_tlast[i], mon_e.d, mon_e.l);
            else passed++;
          end
        end
        prev_stall[i] = (u_tvalid[i] === 1'b1) && (u_tready[i] !== 1'b1);
        prev_d[i]     = u_tdata[i];
        prev_l[i]     = u_tlast[i];
      end
    end
  end

  // Presents a pair. Returns just after the accepting clock edge.
  task automatic send_pair(input int i, input logic [15:0] v, input logic [15:0] c,
                           input bit push);
    bit ok;
    @(posedge clk);
    #1;
    v_tdata[i]  = v;
    c_tdata[i]  = c;
    v_tvalid[i] = 1'b1;
    c_tvalid[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (v_tready[i] === 1'b1 && c_tready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && push) push_frame(i, v[15:4], c[15:4]);
    @(posedge clk);
    #1;
    v_tvalid[i] = 1'b0;
    c_tvalid[i] = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout[%0d]: got no tready, expected pair accepted", i);
    end
  endtask

  task automatic wait_drain(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (qsize(i) == 0 && u_tvalid[i] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) passed++;
    else $display("FAIL drain[%0d]: got %0d bytes outstanding, expected 0", i, qsize(i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v_tdata[i] = '0; c_tdata[i] = '0; v_tvalid[i] = 1'b0; c_tvalid[i] = 1'b0;
      u_tready[i] = 1'b1; mseq[i] = '0; prev_stall[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (u_tvalid[i] !== 1'b0 || u_tlast[i] !== 1'b0 || u_tdata[i] !== 8'h00)
        $display("FAIL reset_usb[%0d]: got valid=%b last=%b data=%h, expected 0 0 00",
                 i, u_tvalid[i], u_tlast[i], u_tdata[i]);
      else passed++;
      checks++;
      if (v_tready[i] !== 1'b0 || c_tready[i] !== 1'b0)
        $display("FAIL reset_ready[%0d]: got %b%b, expected 00", i, v_tready[i], c_tready[i]);
      else passed++;
      checks++;
      if (fc[i] !== 16'd0) $display("FAIL reset_fc[%0d]: got %0d, expected 0", i, fc[i]);
      else passed++;
      checks++;
      if (u_tkeep[i] !== 1'b1 || u_tid[i] !== 1'b0 || u_tdest[i] !== 1'b0 || u_tuser[i] !== 1'b0)
        $display("FAIL const_side[%0d]: got keep=%b id=%b dest=%b user=%b, expected 1 0 0 0",
                 i, u_tkeep[i], u_tid[i], u_tdest[i], u_tuser[i]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    send_pair(0, 16'hABC0, 16'h1230, 1'b1);
    checks++;
    if (u_tvalid[0] !== 1'b1 || u_tdata[0] !== Sync)
      $display("FAIL b0_latency: got valid=%b data=%h, expected 1 %h", u_tvalid[0], u_tdata[0], Sync);
    else passed++;
    checks++;
    if (v_tready[0] !== 1'b0 || c_tready[0] !== 1'b0)
      $display("FAIL ready_in_frame: got %b%b, expected 00", v_tready[0], c_tready[0]);
    else passed++;
    wait_drain(0);
    checks++;
    if (fc[0] !== 16'd1) $display("FAIL single_fc: got %0d, expected 1", fc[0]);
    else passed++;
  endtask

  task automatic test_backpressure();
    int viol;
    viol = 0;
    fork
      begin
        send_pair(0, 16'hABC0, 16'h1230, 1'b1);
        send_pair(0, 16'h5550, 16'hAAA0, 1'b1);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1;
          u_tready[0] = ((k % 4) == 0) || ((k % 4) == 3);
          @(negedge clk);
          if (u_tvalid[0] === 1'b1 && (v_tready[0] === 1'b1 || c_tready[0] === 1'b1)) viol++;
        end
      end
    join
    u_tready[0] = 1'b1;
    wait_drain(0);
    checks++;
    if (viol != 0) $display("FAIL ready_during_frame: got %0d cycles, expected 0", viol);
    else passed++;
    checks++;
    if (fc[0] !== 16'd3) $display("FAIL bp_fc: got %0d, expected 3", fc[0]);
    else passed++;
  endtask

  task automatic test_one_sided();
    int bad;
    bad = 0;
    @(posedge clk);
    #1;
    v_tdata[0]  = 16'h7770;
    v_tvalid[0] = 1'b1;
    c_tvalid[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (v_tready[0] !== 1'b0 || c_tready[0] !== 1'b0 || u_tvalid[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL one_sided: got %0d active cycles, expected 0", bad);
    else passed++;
    send_pair(0, 16'h7770, 16'h8880, 1'b1);
    wait_drain(0);
    checks++;
    if (fc[0] !== 16'd4) $display("FAIL one_sided_fc: got %0d, expected 4", fc[0]);
    else passed++;
  endtask

  task automatic test_decimation();
    for (int n = 1; n <= 12; n++)
      send_pair(1, {12'(n), 4'h0}, {12'(12'h5A0 + n), 4'h0}, (n % 4) == 0);
    wait_drain(1);
    checks++;
    if (fc[1] !== 16'd3) $display("FAIL decim_fc: got %0d, expected 3", fc[1]);
    else passed++;
  endtask

  task automatic test_seq_wrap();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mseq[0] = '0;
    mseq[1] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 257; n++)
      send_pair(0, {12'(n * 7), 4'h0}, {12'(n * 13), 4'h0}, 1'b1);
    wait_drain(0);
    checks++;
    if (fc[0] !== 16'd257) $display("FAIL wrap_fc: got %0d, expected 257", fc[0]);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    send_pair(0, 16'hABC0, 16'h1230, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (u_tvalid[0] !== 1'b1 || u_tdata[0] !== 8'hAB)
      $display("FAIL in_d0: got valid=%b data=%h, expected 1 ab", u_tvalid[0], u_tdata[0]);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_tvalid[0] !== 1'b0 || fc[0] !== 16'd0)
      $display("FAIL async_abort: got valid=%b fc=%0d, expected 0 0", u_tvalid[0], fc[0]);
    else passed++;
    q0.delete();
    q1.delete();
    mseq[0] = '0;
    mseq[1] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pair(0, 16'hABC0, 16'h1230, 1'b1);
    wait_drain(0);
    checks++;
    if (fc[0] !== 16'd1) $display("FAIL post_reset_fc: got %0d, expected 1", fc[0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_one_sided();
    test_decimation();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
